mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the 4:1 single-bit mux between four requesters.
- Drives the mux select (SL) from a registered grant. Holds a grant while the owner keeps requesting, bounded by a fairness timeout.
- Sits directly in front of the Mux4_1 instance; SL connects 1:1 to the mux select, and GNT/VALID go back to the requesters.

---
 rtl/mux4_arb_pkg.sv | 28 ++
 rtl/rr_pick4.sv | 35 +++
 rtl/mux4_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter that drives the
// Mux4_1 select.
//   N_REQ         : number of requesters
//   SEL_W         : width of the mux select / requester index
//   state_t       : arbiter FSM state
//   onehot_to_idx : one-hot grant vector -> requester index
package mux4_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker for four requesters.
//   req     : request vector
//   start   : index that has highest priority; priority falls with distance
//             (start, start+1, ... mod 4)
//   exclude : requesters that may not win this round
//   win     : one-hot winner (all-zero when nothing eligible)
//   any     : at least one eligible requester
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    input  logic [N_REQ-1:0] exclude,
    output logic [N_REQ-1:0] win,
    output logic             any
);

    logic [N_REQ-1:0] cand;

    assign cand = req & ~exclude;
    assign any  = |cand;

    always_comb begin
        win = '0;
        for (int d = 0; d < N_REQ; d++) begin
            logic [SEL_W-1:0] idx;
            // Index arithmetic wraps mod 4 through the 2-bit width.
            idx = start + SEL_W'(d);
            if (win == '0 && cand[idx]) begin
                win[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one Mux4_1 between four requesters.
// The owner keeps the grant while it requests, until MAX_HOLD consecutive
// cycles have elapsed and someone else is waiting (MAX_HOLD = 0: no limit).
//   CLK   : system clock, rising edge
//   RST   : asynchronous active-high reset
//   REQ   : per-requester level request
//   GNT   : registered one-hot grant, zero when idle
//   SL    : index of the granted requester; holds last value when idle
//   VALID : a grant is active
//   LOCK  : (only with MUX4_ARB_LOCK_EN defined) suppresses the hold timeout
//           while a grant is active
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic [SEL_W-1:0] SL,
    output logic             VALID
`ifdef MUX4_ARB_LOCK_EN
    ,
    input  logic             LOCK
`endif
);

    localparam int unsigned CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sl_q, sl_d;
    logic             valid_q, valid_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [SEL_W-1:0] pick_start;
    logic [N_REQ-1:0] pick_excl;
    logic [N_REQ-1:0] pick_win;
    logic             pick_any;
    logic [SEL_W-1:0] win_idx;
    logic             lock_hold;
    logic             timeout;

`ifdef MUX4_ARB_LOCK_EN
    assign lock_hold = valid_q & LOCK;
`else
    assign lock_hold = 1'b0;
`endif

    // Idle: search from the pointer. Busy: search after the owner, never the owner.
    assign pick_start = (state_q == IDLE) ? ptr_q : sl_q + SEL_W'(1);
    assign pick_excl  = (state_q == IDLE) ? '0 : gnt_q;

    rr_pick4 u_pick (
        .req     (REQ),
        .start   (pick_start),
        .exclude (pick_excl),
        .win     (pick_win),
        .any     (pick_any)
    );

    assign win_idx = onehot_to_idx(pick_win);

    // The counter still saturates under LOCK, so dropping LOCK after a long
    // hold rotates on the very next edge.
    assign timeout = (MAX_HOLD != 0) && (cnt_q >= MAX_CNT) && !lock_hold;

    always_comb begin
        logic do_grant;
        do_grant = 1'b0;
        state_d  = state_q;
        gnt_d    = gnt_q;
        sl_d     = sl_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;

        unique case (state_q)
            IDLE: begin
                do_grant = pick_any;
            end
            BUSY: begin
                if (REQ[sl_q]) begin
                    if (timeout && pick_any) begin
                        do_grant = 1'b1;
                    end else if (MAX_HOLD != 0 && cnt_q < MAX_CNT) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (pick_any) begin
                    do_grant = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_grant) begin
            state_d = BUSY;
            gnt_d   = pick_win;
            sl_d    = win_idx;
            valid_d = 1'b1;
            cnt_d   = CW'(1);
            ptr_d   = win_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sl_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sl_q    <= sl_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign GNT   = gnt_q;
    assign SL    = sl_q;
    assign VALID = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (MAX_HOLD = 8).
module tb_mux4_rr_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic [1:0] SL;
    logic       VALID;
`ifdef MUX4_ARB_LOCK_EN
    logic       LOCK;
`endif

    int n_cmp;
    int n_bad;

    mux4_rr_arbiter #(
        .MAX_HOLD (8)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .GNT   (GNT),
        .SL    (SL),
        .VALID (VALID)
`ifdef MUX4_ARB_LOCK_EN
        ,
        .LOCK  (LOCK)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        REQ = 4'b0000;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        REQ = 4'b0000;
        tick();
        n_cmp++;
        if ({GNT, SL, VALID} !== 7'b0000_00_0) begin
            n_bad++;
            $display("FAIL reset_init: GNT/SL/VALID=%b/%0d/%b want 0000/0/0", GNT, SL, VALID);
        end
        // Move the pointer away from 0 before the mid-grant reset.
        RST = 1'b0;
        REQ = 4'b0100;
        tick();
        n_cmp++;
        if ({GNT, SL, VALID} !== 7'b0100_10_1) begin
            n_bad++;
            $display("FAIL reset_pre: GNT/SL/VALID=%b/%0d/%b want 0100/2/1", GNT, SL, VALID);
        end
        REQ = 4'b1111;
        tick();
        #3;
        RST = 1'b1;
        #1;
        n_cmp++;
        if ({GNT, SL, VALID} !== 7'b0000_00_0) begin
            n_bad++;
            $display("FAIL reset_async: GNT/SL/VALID=%b/%0d/%b want 0000/0/0", GNT, SL, VALID);
        end
        tick();
        RST = 1'b0;
        tick();
        n_cmp++;
        if ({GNT, SL, VALID} !== 7'b0001_00_1) begin
            n_bad++;
            $display("FAIL reset_first: GNT/SL/VALID=%b/%0d/%b want 0001/0/1", GNT, SL, VALID);
        end
        REQ = 4'b0000;
        tick();
    endtask

    task automatic test_single();
        REQ = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({GNT, SL, VALID} !== 7'b0100_10_1) begin
                n_bad++;
                $display("FAIL single_hold%0d: GNT/SL/VALID=%b/%0d/%b want 0100/2/1",
                         i, GNT, SL, VALID);
            end
        end
        REQ = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({GNT, SL, VALID} !== 7'b0000_10_0) begin
                n_bad++;
                $display("FAIL single_idle%0d: GNT/SL/VALID=%b/%0d/%b want 0000/2/0",
                         i, GNT, SL, VALID);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] e_gnt;
        apply_reset();
        REQ = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            e_gnt = 4'b0001 << (k % 4);
            for (int c = 0; c < 2; c++) begin
                n_cmp++;
                if ({GNT, SL, VALID} !== {e_gnt, 2'(k % 4), 1'b1}) begin
                    n_bad++;
                    $display("FAIL rotate%0d_%0d: GNT/SL/VALID=%b/%0d/%b want %b/%0d/1",
                             k, c, GNT, SL, VALID, e_gnt, k % 4);
                end
                if (c == 0) tick();
            end
            REQ = 4'b1111 & ~e_gnt;
            tick();
            REQ = 4'b1111;
        end
    endtask

    task automatic test_timeout();
        logic [3:0] e_gnt;
        apply_reset();
        REQ = 4'b0011;
        for (int i = 0; i < 24; i++) begin
            tick();
            e_gnt = 4'b0001 << ((i / 8) % 2);
            n_cmp++;
            if ({GNT, VALID} !== {e_gnt, 1'b1}) begin
                n_bad++;
                $display("FAIL timeout_alt%0d: GNT/VALID=%b/%b want %b/1", i, GNT, VALID, e_gnt);
            end
        end
        REQ = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if ({GNT, SL, VALID} !== 7'b0001_00_1) begin
                n_bad++;
                $display("FAIL timeout_solo%0d: GNT/SL/VALID=%b/%0d/%b want 0001/0/1",
                         i, GNT, SL, VALID);
            end
        end
        // Counter must have saturated, so a newcomer wins on the next edge.
        REQ = 4'b0011;
        tick();
        n_cmp++;
        if ({GNT, SL, VALID} !== 7'b0010_01_1) begin
            n_bad++;
            $display("FAIL timeout_sat: GNT/SL/VALID=%b/%0d/%b want 0010/1/1", GNT, SL, VALID);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        REQ = 4'b1000;
        tick();
        REQ = 4'b1001;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        n_cmp++;
        if ({GNT, SL, VALID} !== 7'b1000_11_1) begin
            n_bad++;
            $display("FAIL wrap_hold: GNT/SL/VALID=%b/%0d/%b want 1000/3/1", GNT, SL, VALID);
        end
        tick();
        n_cmp++;
        if ({GNT, SL, VALID} !== 7'b0001_00_1) begin
            n_bad++;
            $display("FAIL wrap_grant: GNT/SL/VALID=%b/%0d/%b want 0001/0/1", GNT, SL, VALID);
        end
        REQ = 4'b0000;
        tick();
        n_cmp++;
        if ({GNT, SL, VALID} !== 7'b0000_00_0) begin
            n_bad++;
            $display("FAIL wrap_idle: GNT/SL/VALID=%b/%0d/%b want 0000/0/0", GNT, SL, VALID);
        end
        // Pointer now 1: requester 1 beats requester 0.
        REQ = 4'b1111;
        tick();
        n_cmp++;
        if ({GNT, SL, VALID} !== 7'b0010_01_1) begin
            n_bad++;
            $display("FAIL wrap_ptr: GNT/SL/VALID=%b/%0d/%b want 0010/1/1", GNT, SL, VALID);
        end
        REQ = 4'b0000;
        tick();
    endtask

`ifdef MUX4_ARB_LOCK_EN
    task automatic test_lock();
        apply_reset();
        LOCK = 1'b1;
        REQ  = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if ({GNT, VALID} !== 5'b0001_1) begin
                n_bad++;
                $display("FAIL lock_hold%0d: GNT/VALID=%b/%b want 0001/1", i, GNT, VALID);
            end
        end
        LOCK = 1'b0;
        tick();
        n_cmp++;
        if ({GNT, SL, VALID} !== 7'b0010_01_1) begin
            n_bad++;
            $display("FAIL lock_release: GNT/SL/VALID=%b/%0d/%b want 0010/1/1", GNT, SL, VALID);
        end
        REQ = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RST   = 1'b1;
        REQ   = 4'b0000;
`ifdef MUX4_ARB_LOCK_EN
        LOCK  = 1'b0;
`endif
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_wrap();
`ifdef MUX4_ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
